// File: rtl/pipe_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Parametrised pipeline controller for the 16-bit Thumb core.
//               Tracks the instruction and valid bit of every stage from ID
//               to WB. Stalls ID/EX/MEM during multi-cycle memory accesses
//               and inserts bubbles behind them. Resolves branches in EX and
//               flushes the front end. Decodes the register-file write port
//               from the WB-stage instruction.
//
// Parameters  : STAGES     - tracked stages ID..WB (4..8); 0=ID, 1=EX, 2=MEM,
//                            STAGES-1=WB, anything between is pure delay
//               MEM_CYCLES - cycles a load/store occupies MEM (1..15)
// Macro       : PIPE_CTRL_FULLCOND_EN - full EQ..LE condition table; when
//               undefined every conditional branch uses Z | (N != V)
//
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               i_ir_id/i_ir_valid - instruction presented to ID
//               i_apsr             - flags {N,Z,C,V}
//               o_stall            - per-stage hold vector
//               o_flush            - fetch discards its in-flight instruction
//               o_branch_taken     - taken branch resolved in EX this cycle
//               o_addr_mode        - 00 sequential PC, 01 branch target
//               o_rd_addr_r/o_rd_en_r - register-file write port for WB
//
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int STAGES     = 4,
    parameter int MEM_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       i_ir_id,
    input  logic              i_ir_valid,
    input  logic [3:0]        i_apsr,
    output logic [STAGES-1:0] o_stall,
    output logic              o_flush,
    output logic              o_branch_taken,
    output logic [1:0]        o_addr_mode,
    output logic [2:0]        o_rd_addr_r,
    output logic              o_rd_en_r
);

    localparam int         c_wb         = STAGES - 1;
    localparam logic [3:0] c_mem_reload = 4'(MEM_CYCLES - 1);

    logic [STAGES-1:0][15:0] r_ir;
    logic [STAGES-1:0]       r_v;
    logic [3:0]              r_mcnt;

    logic [STAGES-1:0][15:0] w_ir_nxt;
    logic [STAGES-1:0]       w_v_nxt;
    logic [STAGES-1:0]       w_stall;
    logic                    w_mem_busy;
    logic                    w_ls_ex;
    logic                    w_cond_br;
    logic                    w_uncond_br;
    logic                    w_cond_ok;
    logic                    w_taken;
    logic [15:0]             w_wb_ir;
    logic                    w_unused;

    // ------------------------------------------------------------------
    // Memory wait: ID, EX and MEM freeze while the counter runs; later
    // stages keep draining so WB sees bubbles.
    // ------------------------------------------------------------------
    assign w_mem_busy = (r_mcnt != 4'd0);
    assign w_stall    = w_mem_busy ? {{(STAGES-3){1'b0}}, 3'b111} : '0;
    assign w_ls_ex    = r_v[1] && (r_ir[1][15:12] inside {4'h5, 4'h6, 4'h7, 4'h8, 4'h9});

    // ------------------------------------------------------------------
    // Branch resolution in EX. A branch held behind a busy MEM is not
    // evaluated until the counter reaches zero.
    // ------------------------------------------------------------------
    assign w_cond_br   = (r_ir[1][15:12] == 4'b1101) && (r_ir[1][11:9] != 3'b111);
    assign w_uncond_br = (r_ir[1][15:11] == 5'b11100);

`ifdef PIPE_CTRL_FULLCOND_EN
    // i_apsr = {N,Z,C,V}
    always_comb begin
        w_cond_ok = 1'b0;
        case (r_ir[1][11:8])
            4'h0: w_cond_ok = i_apsr[2];
            4'h1: w_cond_ok = ~i_apsr[2];
            4'h2: w_cond_ok = i_apsr[1];
            4'h3: w_cond_ok = ~i_apsr[1];
            4'h4: w_cond_ok = i_apsr[3];
            4'h5: w_cond_ok = ~i_apsr[3];
            4'h6: w_cond_ok = i_apsr[0];
            4'h7: w_cond_ok = ~i_apsr[0];
            4'h8: w_cond_ok = i_apsr[1] & ~i_apsr[2];
            4'h9: w_cond_ok = ~i_apsr[1] | i_apsr[2];
            4'hA: w_cond_ok = (i_apsr[3] == i_apsr[0]);
            4'hB: w_cond_ok = (i_apsr[3] != i_apsr[0]);
            4'hC: w_cond_ok = ~i_apsr[2] & (i_apsr[3] == i_apsr[0]);
            4'hD: w_cond_ok = i_apsr[2] | (i_apsr[3] != i_apsr[0]);
            default: w_cond_ok = 1'b0;
        endcase
    end
    assign w_unused = ^w_wb_ir[5:3];
`else
    // Legacy core: one fixed predicate regardless of the condition field
    assign w_cond_ok = i_apsr[2] | (i_apsr[3] ^ i_apsr[0]);
    assign w_unused  = ^{w_wb_ir[5:3], i_apsr[1]};
`endif

    assign w_taken = r_v[1] & ~w_mem_busy & ((w_cond_br & w_cond_ok) | w_uncond_br);

    assign o_stall        = w_stall;
    assign o_flush        = w_taken;
    assign o_branch_taken = w_taken;
    assign o_addr_mode    = {1'b0, w_taken};

    // ------------------------------------------------------------------
    // Stage advance. A taken branch kills both the instruction in ID
    // (it enters EX as a bubble) and the one being fetched into ID.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_id
            assign w_ir_nxt[k] = w_stall[k] ? r_ir[k] : (w_taken ? 16'h0000 : i_ir_id);
            assign w_v_nxt[k]  = w_stall[k] ? r_v[k]  : (i_ir_valid & ~w_taken);
        end else begin : g_next
            logic w_bubble;
            assign w_bubble    = w_stall[k-1] | ((k == 1) & w_taken);
            assign w_ir_nxt[k] = w_stall[k] ? r_ir[k] : (w_bubble ? 16'h0000 : r_ir[k-1]);
            assign w_v_nxt[k]  = w_stall[k] ? r_v[k]  : (~w_bubble & r_v[k-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ir   <= '0;
            r_v    <= '0;
            r_mcnt <= 4'd0;
        end else begin
            r_ir <= w_ir_nxt;
            r_v  <= w_v_nxt;
            // EX cannot move while busy, so a reload only happens when MEM is
            // free; with MEM_CYCLES = 1 the reload value is zero.
            if (w_mem_busy) begin
                r_mcnt <= r_mcnt - 4'd1;
            end else if (w_ls_ex) begin
                r_mcnt <= c_mem_reload;
            end
        end
    end

    // ------------------------------------------------------------------
    // Write-back decode from the registered WB stage.
    // ------------------------------------------------------------------
    assign w_wb_ir = r_ir[c_wb];

    always_comb begin
        o_rd_en_r   = 1'b0;
        o_rd_addr_r = 3'd0;
        if (r_v[c_wb]) begin
            if (w_wb_ir[15:13] == 3'b000) begin
                o_rd_en_r   = 1'b1;
                o_rd_addr_r = w_wb_ir[2:0];
            end else if ((w_wb_ir[15:13] == 3'b001) && (w_wb_ir[12:11] != 2'b01)) begin
                o_rd_en_r   = 1'b1;
                o_rd_addr_r = w_wb_ir[10:8];
            end else if ((w_wb_ir[15:10] == 6'b010000) &&
                         !(w_wb_ir[9:6] inside {4'b1000, 4'b1010, 4'b1011})) begin
                o_rd_en_r   = 1'b1;
                o_rd_addr_r = w_wb_ir[2:0];
            end else if (w_wb_ir[15:11] inside {5'b01101, 5'b01111, 5'b10001}) begin
                o_rd_en_r   = 1'b1;
                o_rd_addr_r = w_wb_ir[2:0];
            end else if (w_wb_ir[15:11] == 5'b10011) begin
                o_rd_en_r   = 1'b1;
                o_rd_addr_r = w_wb_ir[10:8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Self-checking bench for pipe_ctrl (STAGES=4, MEM_CYCLES=3).
//               Expected write-backs are queued at issue and popped when the
//               WB port fires; timing and branch behaviour are checked
//               cycle by cycle against values derived here.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int STAGES     = 4;
    localparam int MEM_CYCLES = 3;
`ifdef PIPE_CTRL_FULLCOND_EN
    localparam bit FULL = 1'b1;
`else
    localparam bit FULL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       i_ir_id;
    logic              i_ir_valid;
    logic [3:0]        i_apsr;
    logic [STAGES-1:0] o_stall;
    logic              o_flush;
    logic              o_branch_taken;
    logic [1:0]        o_addr_mode;
    logic [2:0]        o_rd_addr_r;
    logic              o_rd_en_r;

    always #5 clk = ~clk;

    pipe_ctrl #(.STAGES(STAGES), .MEM_CYCLES(MEM_CYCLES)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_ir_id        (i_ir_id),
        .i_ir_valid     (i_ir_valid),
        .i_apsr         (i_apsr),
        .o_stall        (o_stall),
        .o_flush        (o_flush),
        .o_branch_taken (o_branch_taken),
        .o_addr_mode    (o_addr_mode),
        .o_rd_addr_r    (o_rd_addr_r),
        .o_rd_en_r      (o_rd_en_r)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] sb_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Reference write-back decode: {enable, rd}
    function automatic logic [3:0] ref_wb(input logic [15:0] ir);
        logic [4:0] top;
        top = ir[15:11];
        casez (top)
            5'b000??: return {1'b1, ir[2:0]};
            5'b00100, 5'b00110, 5'b00111: return {1'b1, ir[10:8]};
            5'b01000: begin
                if (ir[10] == 1'b0 && ir[9:6] != 4'd8 && ir[9:6] != 4'd10 && ir[9:6] != 4'd11)
                    return {1'b1, ir[2:0]};
                return 4'h0;
            end
            5'b01101, 5'b01111, 5'b10001: return {1'b1, ir[2:0]};
            5'b10011: return {1'b1, ir[10:8]};
            default: return 4'h0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction, wait until ID accepts it, queue its write.
    task automatic issue(input logic [15:0] ir, input bit keep);
        logic [3:0] e;
        int guard;
        guard = 0;
        i_ir_id    = ir;
        i_ir_valid = 1'b1;
        while (o_stall[0] && guard < 50) begin
            step();
            guard++;
        end
        if (guard >= 50) check("issue_timeout", guard, 0);
        step();
        e = ref_wb(ir);
        if (keep && e[3]) sb_q.push_back(e[2:0]);
        i_ir_id    = 16'h0000;
        i_ir_valid = 1'b0;
    endtask

    task automatic branch_case(input string tag, input logic [15:0] br,
                               input logic [3:0] apsr, input bit exp_taken);
        i_apsr = apsr;
        issue(br, 1'b1);
        issue(16'h18D1, !exp_taken);   // sits in ID while branch is in EX
        check({tag, "_taken"}, o_branch_taken, exp_taken);
        check({tag, "_flush"}, o_flush, exp_taken);
        check({tag, "_mode"}, o_addr_mode, exp_taken ? 2'b01 : 2'b00);
        issue(16'h18D2, !exp_taken);   // fetched during the resolve cycle
        check({tag, "_taken_pulse"}, o_branch_taken, 0);
        check({tag, "_flush_pulse"}, o_flush, 0);
        repeat (4) step();
    endtask

    always @(negedge clk) begin
        if (!rst && o_rd_en_r) begin
            if (sb_q.size() == 0) check("wb_unexpected_write", sb_q.size(), 1);
            else check("wb_rd", o_rd_addr_r, sb_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] stream [8];
        int st_cnt, st_first, wb_first, fl_cnt, fl_step;

        stream = '{16'h18D1, 16'h2534, 16'h2A01, 16'h400B,
                   16'h4213, 16'h3701, 16'h42D6, 16'h004E};

        rst = 1'b1; i_ir_id = 16'hE005; i_ir_valid = 1'b1; i_apsr = 4'b0100;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", o_stall, 0);
        check("rst_flush", o_flush, 0);
        check("rst_taken", o_branch_taken, 0);
        check("rst_mode", o_addr_mode, 0);
        check("rst_rd_en", o_rd_en_r, 0);
        check("rst_rd_addr", o_rd_addr_r, 0);
        i_ir_id = 16'h0000; i_ir_valid = 1'b0; i_apsr = 4'b0000;
        #2 rst = 1'b0;
        step();

        // Latency: accepted at edge t, visible at WB after edge t+3
        issue(16'h18D1, 1'b1);
        step(); check("lat_t1_en", o_rd_en_r, 0);
        step(); check("lat_t2_en", o_rd_en_r, 0);
        step(); check("lat_t3_en", o_rd_en_r, 1);
        check("lat_t3_rd", o_rd_addr_r, 1);
        check("lat_stall", o_stall, 0);

        // Back-to-back ALU stream, mixed writers and non-writers
        foreach (stream[i]) issue(stream[i], 1'b1);
        repeat (5) step();

        // Single LDR: stall window and WB arrival
        st_cnt = 0; st_first = -1; wb_first = -1;
        issue(16'h6808, 1'b1);
        for (int n = 1; n <= 10; n++) begin
            step();
            if (o_stall[2:0] == 3'b111) begin
                if (st_first < 0) begin
                    st_first = n;
                    check("ldr_stall_vec", o_stall, 4'b0111);
                end
                st_cnt++;
            end
            if (o_rd_en_r && wb_first < 0) wb_first = n;
        end
        check("ldr_stall_first", st_first, 2);
        check("ldr_stall_cnt", st_cnt, MEM_CYCLES - 1);
        check("ldr_wb_cycle", wb_first, MEM_CYCLES + 2);

        // Back-to-back load/stores each pay the full wait
        st_cnt = 0;
        issue(16'h6808, 1'b1);
        issue(16'h9A00, 1'b1);
        for (int n = 1; n <= 14; n++) begin
            step();
            if (o_stall[2:0] == 3'b111) st_cnt++;
        end
        check("b2b_stall_cnt", st_cnt, 2 * (MEM_CYCLES - 1));

        // Branch resolution
        branch_case("beq_z1", 16'hD005, 4'b0100, 1'b1);
        branch_case("beq_z0", 16'hD005, 4'b0000, 1'b0);
        branch_case("bgt",    16'hDC05, 4'b1001, FULL);
        branch_case("bne_z1", 16'hD105, 4'b0100, !FULL);
        branch_case("b_unc",  16'hE005, 4'b0000, 1'b1);
        branch_case("svc",    16'hDF05, 4'b0100, 1'b0);

        // LDR then BEQ: branch waits for MEM, flush pulses once
        i_apsr = 4'b0100;
        st_cnt = 0; fl_cnt = 0; fl_step = -1;
        issue(16'h6808, 1'b1);
        issue(16'hD005, 1'b1);
        for (int n = 1; n <= 8; n++) begin
            step();
            if (o_stall[2:0] == 3'b111) st_cnt++;
            if (o_flush) begin
                fl_cnt++;
                if (fl_step < 0) fl_step = n;
            end
        end
        check("ldbr_stall_cnt", st_cnt, MEM_CYCLES - 1);
        check("ldbr_flush_cnt", fl_cnt, 1);
        check("ldbr_flush_step", fl_step, MEM_CYCLES);
        i_apsr = 4'b0000;
        repeat (4) step();

        // Reset in the middle of a memory wait
        issue(16'h6808, 1'b1);
        step(); step();
        check("mrst_pre_stall", o_stall, 4'b0111);
        #2 rst = 1'b1;
        #1;
        check("mrst_stall", o_stall, 0);
        check("mrst_flush", o_flush, 0);
        check("mrst_taken", o_branch_taken, 0);
        check("mrst_mode", o_addr_mode, 0);
        check("mrst_rd_en", o_rd_en_r, 0);
        check("mrst_rd_addr", o_rd_addr_r, 0);
        sb_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        step();
        issue(16'h18D4, 1'b1);
        for (int n = 1; n <= 3; n++) begin
            step();
            check("mrst_post_stall", o_stall, 0);
        end
        check("mrst_post_en", o_rd_en_r, 1);
        check("mrst_post_rd", o_rd_addr_r, 4);

        repeat (6) step();
        check("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the 16-bit Thumb core. It generalises the fixed four-stage ID/EX/MEM/WB controller:
- configurable stage count and memory-access length;
- per-stage valid tracking with bubble insertion;
- full condition-code branch resolution in EX with front-end flush;
- write-back register-enable decode.

It sits between the fetch unit (`o_flush`, `o_addr_mode`) and the datapath (per-stage stall vector, register-file write port).

## Interface
- `STAGES`, 4: tracked stages from ID to WB.
  - Legal range 4..8.
  - Index 0 = ID, 1 = EX, 2 = MEM, STAGES-1 = WB.
  - Indices 3..STAGES-2 are pure delay stages.
- `MEM_CYCLES`, 2: cycles a load/store occupies MEM. Legal range 1..15.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_ir_id` in 16: instruction presented to ID.
- `i_ir_valid` in 1: `i_ir_id` is a real instruction.
- `i_apsr` in 4: flags {N,Z,C,V} (bit3 = N, bit0 = V).
- `o_stall` out STAGES: bit k = 1 means stage k holds its register this cycle.
- `o_flush` out 1: fetch discards its in-flight instruction.
- `o_branch_taken` out 1: taken branch resolved in EX this cycle.
- `o_addr_mode` out 2: 00 = sequential PC, 01 = ALU/branch target.
- `o_rd_addr_r` out 3: destination register of the WB-stage instruction.
- `o_rd_en_r` out 1: register-file write enable for the WB-stage instruction.

## Operation
State:
- per-stage `ir[k]` (16 bit) and `v[k]`;
- memory counter `mcnt` (4 bit).

Advance:
- A stage that is not stalled loads from the stage before it. Stage 0 loads {`i_ir_id`, `i_ir_valid`}.
- A stage that is stalled keeps its contents.
- A stage whose predecessor is stalled but which is itself not stalled loads a bubble (`v`=0, `ir`=0).

Load/store detection and memory wait:
- Load/store: `ir[15:12]` ∈ {0101, 0110, 0111, 1000, 1001}.
- When a valid load/store moves EX→MEM and MEM_CYCLES > 1, set `mcnt` = MEM_CYCLES-1.
- While `mcnt` ≠ 0:
  - `o_stall[2:0]` = 111;
  - stages ≥ 3 advance, so WB receives a bubble;
  - `mcnt` decrements each cycle.

Branch resolution (`mem_busy` = (`mcnt` ≠ 0)):
- Conditional branch: `ir[1][15:12]` = 1101 and `ir[1][11:9]` ≠ 111.
  - Taken = `v[1]` & ~`mem_busy` & cond(`ir[1][11:8]`, `i_apsr`), using the ARM EQ..LE table (0000..1101).
- Unconditional branch: `ir[1][15:11]` = 11100, taken when `v[1]` & ~`mem_busy`.
- Taken, combinational in the same cycle:
  - `o_branch_taken` = 1, `o_addr_mode` = 01, `o_flush` = 1;
  - `v[0]` is squashed, so the ID instruction enters EX as a bubble;
  - stage 0 loads a bubble instead of `i_ir_id`.

Write-back decode (registered; outputs are a pure function of `ir[STAGES-1]` and `v[STAGES-1]`):
- `ir[15:13]` = 000 → rd = `ir[2:0]`.
- `ir[15:13]` = 001 and `ir[12:11]` ≠ 01 (CMP excluded) → rd = `ir[10:8]`.
- `ir[15:10]` = 010000 and `ir[9:6]` ∉ {1000, 1010, 1011} (TST, CMP, CMN) → rd = `ir[2:0]`.
- `ir[15:11]` ∈ {01101, 01111, 10001, 10011} (loads) → rd = `ir[2:0]`, except 10011 → `ir[10:8]`.
- Otherwise or `v` = 0 → `o_rd_en_r` = 0, `o_rd_addr_r` = 0.

## Timing
- Reset (async assert, synchronous-edge release):
  - all `v` = 0, all `ir` = 0, `mcnt` = 0;
  - `o_stall` = 0, `o_flush` = 0, `o_branch_taken` = 0, `o_addr_mode` = 00, `o_rd_en_r` = 0, `o_rd_addr_r` = 0.
- Latency: an instruction accepted at edge t reaches WB at edge t+STAGES-1 when no stalls occur.
- Load/store: MEM_CYCLES-1 stall cycles per access; back-to-back load/stores each pay the full count.
- A branch held in EX by `mem_busy` is evaluated in the first cycle `mcnt` = 0, using `i_apsr` of that cycle.
- Branch taken and load/store both present in the same cycle is impossible; a branch in EX always sees MEM free or busy as above.
- Reset mid-stall clears `mcnt` immediately; no pending flush survives reset.
- `o_flush` is a one-cycle pulse per taken branch.

## Configuration
- `PIPE_CTRL_FULLCOND_EN` defined: full 14-entry condition table as above.
- Undefined: legacy evaluation. Every conditional branch is taken when (Z = 1) | (N ≠ V), regardless of `ir[11:8]`. The unconditional branch is unaffected.

## Test plan
- Reset then stream ADD r1,r2,r3 (16'h18D1) with `i_ir_valid`=1, STAGES=4 → `o_rd_en_r`=1, `o_rd_addr_r`=1 exactly 3 cycles after acceptance; all `o_stall`=0.
- LDR (16'h6808), MEM_CYCLES=3 → `o_stall[2:0]`=111 for exactly 2 cycles after it enters MEM; WB shows 2 bubbles (`o_rd_en_r`=0) then rd=0 enabled.
- BEQ (16'hD0xx) in EX with `i_apsr`=4'b0100 → `o_branch_taken`=`o_flush`=1, `o_addr_mode`=01 for one cycle; next instruction in EX is a bubble. With `i_apsr`=0 → not taken.
- BGT (16'hDCxx), `i_apsr`={N=1,Z=0,C=0,V=1}: FULLCOND_EN → taken; legacy build → not taken.
- LDR followed by BEQ, MEM_CYCLES=4 → branch resolves only after 3 stall cycles; `o_flush` pulses once.
- Assert `rst` while `mcnt`=2 → all outputs 0 asynchronously; after release, the first new instruction flows with no residual stall.
